// File: rtl/rt_rgu_scan.sv
// rt_rgu_scan: frame-scanning primary ray generator.
// Counters feed an issue reg, then coordinate, multiply and sum stages.
module rt_rgu_scan #(
   parameter int IW       = 16,
   parameter int QW       = 16,
   parameter int XW       = 11,
   parameter int YW       = 11,
   parameter int SPP_LOG2 = 0,
   parameter int JITTER   = 0,
   localparam int WL      = IW + QW,
   localparam int SW      = (SPP_LOG2 > 0) ? SPP_LOG2 : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [XW-1:0] img_w,
   input  logic [YW-1:0] img_h,
   input  logic [WL-1:0] pixel_00_loc [3],
   input  logic [WL-1:0] pixel_delta_u [3],
   input  logic [WL-1:0] pixel_delta_v [3],
   input  logic [WL-1:0] camera_center [3],
   input  logic [15:0]   seed,
   output logic          busy,
   output logic          done,
   output logic          ray_valid,
   input  logic          ray_ready,
   output logic [WL-1:0] ray_origin [3],
   output logic [WL-1:0] ray_direction [3],
   output logic [XW-1:0] ray_x,
   output logic [YW-1:0] ray_y,
   output logic [SW-1:0] ray_sample,
   output logic          ray_last
);

   localparam int SPP = 1 << SPP_LOG2;
   localparam int TW  = XW + YW + SW + 1;
   localparam int PW  = WL + QW;
   localparam int LSH = (QW > 16) ? QW - 16 : 0;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   function automatic logic [15:0] f_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   // LFSR bits form the fraction, recentred to [-0.5, 0.5)
   function automatic logic [WL-1:0] f_ofs(input logic [15:0] l);
      return WL'(QW'({{QW{1'b0}}, l} << LSH)) - (WL'(1) << (QW - 1));
   endfunction

   state_t        r_state;
   logic [XW-1:0] r_w, r_x;
   logic [YW-1:0] r_h, r_y;
   logic [SW-1:0] r_s;
   logic [WL-1:0] r_p00 [3];
   logic [WL-1:0] r_du [3];
   logic [WL-1:0] r_dv [3];
   logic [WL-1:0] r_cc [3];
   logic [15:0]   r_lfsr;

   logic          r0_v, r1_v, r2_v;
   logic [TW-1:0] r0_tag, r1_tag, r2_tag;
   logic [WL-1:0] r0_ox, r0_oy, r1_sx, r1_sy;
   logic [WL-1:0] r2_pu [3];
   logic [WL-1:0] r2_pv [3];

   logic                 w_adv, w_run;
   logic                 w_s_end, w_x_end, w_y_end, w_last;
   logic [15:0]          w_l1, w_l2;
   logic [WL-1:0]        w_ox, w_oy;
   logic signed [PW-1:0] w_mu [3];
   logic signed [PW-1:0] w_mv [3];

   assign w_adv   = !(ray_valid && !ray_ready);
   assign w_run   = (r_state == S_RUN);
   assign w_s_end = (r_s == SW'(SPP - 1));
   assign w_x_end = (r_x == r_w - XW'(1));
   assign w_y_end = (r_y == r_h - YW'(1));
   assign w_last  = w_run && w_s_end && w_x_end && w_y_end;
   assign w_l1    = f_step(r_lfsr);
   assign w_l2    = f_step(w_l1);
   assign w_ox    = (JITTER != 0) ? f_ofs(r_lfsr) : '0;
   assign w_oy    = (JITTER != 0) ? f_ofs(w_l1) : '0;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_mu[i] = $signed(PW'($signed(r1_sx))) * $signed(PW'($signed(r_du[i])));
         w_mv[i] = $signed(PW'($signed(r1_sy))) * $signed(PW'($signed(r_dv[i])));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         r_w     <= '0;
         r_h     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_s     <= '0;
         r_lfsr  <= 16'hACE1;
         for (int i = 0; i < 3; i++) begin
            r_p00[i] <= '0;
            r_du[i]  <= '0;
            r_dv[i]  <= '0;
            r_cc[i]  <= '0;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_w    <= img_w;
                  r_h    <= img_h;
                  r_x    <= '0;
                  r_y    <= '0;
                  r_s    <= '0;
                  r_lfsr <= (seed == 16'd0) ? 16'hACE1 : seed;
                  for (int i = 0; i < 3; i++) begin
                     r_p00[i] <= pixel_00_loc[i];
                     r_du[i]  <= pixel_delta_u[i];
                     r_dv[i]  <= pixel_delta_v[i];
                     r_cc[i]  <= camera_center[i];
                  end
                  if (img_w != '0 && img_h != '0) begin
                     r_state <= S_RUN;
                     busy    <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_adv) begin
                  r_lfsr <= w_l2;
                  if (w_s_end) begin
                     r_s <= '0;
                     if (w_x_end) begin
                        r_x <= '0;
                        r_y <= r_y + YW'(1);
                     end else begin
                        r_x <= r_x + XW'(1);
                     end
                  end else begin
                     r_s <= r_s + SW'(1);
                  end
                  if (w_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (ray_valid && ray_ready && ray_last) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_v       <= 1'b0;
         r1_v       <= 1'b0;
         r2_v       <= 1'b0;
         r0_tag     <= '0;
         r1_tag     <= '0;
         r2_tag     <= '0;
         r0_ox      <= '0;
         r0_oy      <= '0;
         r1_sx      <= '0;
         r1_sy      <= '0;
         ray_valid  <= 1'b0;
         ray_x      <= '0;
         ray_y      <= '0;
         ray_sample <= '0;
         ray_last   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r2_pu[i]         <= '0;
            r2_pv[i]         <= '0;
            ray_origin[i]    <= '0;
            ray_direction[i] <= '0;
         end
      end else if (w_adv) begin
         r0_v   <= w_run;
         r0_tag <= {r_x, r_y, r_s, w_last};
         r0_ox  <= w_ox;
         r0_oy  <= w_oy;

         r1_v   <= r0_v;
         r1_tag <= r0_tag;
         r1_sx  <= WL'({r0_tag[TW-1 -: XW], {QW{1'b0}}}) + r0_ox;
         r1_sy  <= WL'({r0_tag[SW+1 +: YW], {QW{1'b0}}}) + r0_oy;

         r2_v   <= r1_v;
         r2_tag <= r1_tag;
         for (int i = 0; i < 3; i++) begin
            r2_pu[i] <= WL'(w_mu[i] >> QW);
            r2_pv[i] <= WL'(w_mv[i] >> QW);
         end

         ray_valid  <= r2_v;
         ray_x      <= r2_tag[TW-1 -: XW];
         ray_y      <= r2_tag[SW+1 +: YW];
         ray_sample <= r2_tag[1 +: SW];
         ray_last   <= r2_v && r2_tag[0];
         for (int i = 0; i < 3; i++) begin
            ray_origin[i]    <= r_cc[i];
            ray_direction[i] <= r_p00[i] + r2_pu[i] + r2_pv[i] - r_cc[i];
         end
      end
   end

endmodule

// File: tb/tb_rt_rgu_scan.sv
// tb_rt_rgu_scan: scoreboard bench for the ray generator.
// Stimulus pushes expected rays; negedge monitors pop and compare.
module tb_rt_rgu_scan;

   typedef struct packed {
      logic [2:0][31:0] d;
      logic [2:0][31:0] o;
      logic [10:0]      x;
      logic [10:0]      y;
      logic [1:0]       s;
      logic             last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] p00 [3];
   logic [31:0] du [3];
   logic [31:0] dv [3];
   logic [31:0] cc [3];
   logic [15:0] seed;

   logic        a_start, a_busy, a_done, a_valid, a_ready, a_last;
   logic [10:0] a_w, a_x;
   logic [10:0] a_h, a_y;
   logic [0:0]  a_s;
   logic [31:0] a_org [3];
   logic [31:0] a_dir [3];

   logic        b_start, b_busy, b_done, b_valid, b_ready, b_last;
   logic [10:0] b_w, b_x;
   logic [10:0] b_h, b_y;
   logic [1:0]  b_s;
   logic [31:0] b_org [3];
   logic [31:0] b_dir [3];

   exp_t a_q[$];
   exp_t b_q[$];
   exp_t a_snap;
   logic a_stall = 1'b0;
   logic tog_en = 1'b0;
   logic [3:0] pat = 4'b1001;
   int checks = 0;
   int errors = 0;

   assign b_ready = 1'b1;

   always #5 clk = ~clk;

   rt_rgu_scan u_a (
      .clk(clk), .rst(rst), .start(a_start), .img_w(a_w), .img_h(a_h),
      .pixel_00_loc(p00), .pixel_delta_u(du), .pixel_delta_v(dv),
      .camera_center(cc), .seed(seed), .busy(a_busy), .done(a_done),
      .ray_valid(a_valid), .ray_ready(a_ready), .ray_origin(a_org),
      .ray_direction(a_dir), .ray_x(a_x), .ray_y(a_y),
      .ray_sample(a_s), .ray_last(a_last)
   );

   rt_rgu_scan #(.SPP_LOG2(2), .JITTER(1)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .img_w(b_w), .img_h(b_h),
      .pixel_00_loc(p00), .pixel_delta_u(du), .pixel_delta_v(dv),
      .camera_center(cc), .seed(seed), .busy(b_busy), .done(b_done),
      .ray_valid(b_valid), .ray_ready(b_ready), .ray_origin(b_org),
      .ray_direction(b_dir), .ray_x(b_x), .ray_y(b_y),
      .ray_sample(b_s), .ray_last(b_last)
   );

   function automatic exp_t mk(input logic [31:0] d0, d1, d2, o0, o1, o2,
                               input int x, y, s, input logic last);
      exp_t e;
      e.d = {d2, d1, d0};
      e.o = {o2, o1, o0};
      e.x = 11'(x);
      e.y = 11'(y);
      e.s = 2'(s);
      e.last = last;
      return e;
   endfunction

   function automatic exp_t get_a();
      return mk(a_dir[0], a_dir[1], a_dir[2], a_org[0], a_org[1], a_org[2],
                int'(a_x), int'(a_y), int'(a_s), a_last);
   endfunction

   function automatic exp_t get_b();
      return mk(b_dir[0], b_dir[1], b_dir[2], b_org[0], b_org[1], b_org[2],
                int'(b_x), int'(b_y), int'(b_s), b_last);
   endfunction

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic logic [31:0] mq(input logic [31:0] a, b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return 32'(p >>> 16);
   endfunction

   task automatic check(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, exp, exp);
      end
   endtask

   task automatic chk_ray(input string nm, input exp_t g, input exp_t e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got d=%h o=%h x=%0d y=%0d s=%0d last=%b want d=%h o=%h x=%0d y=%0d s=%0d last=%b",
                  nm, g.d, g.o, g.x, g.y, g.s, g.last, e.d, e.o, e.x, e.y, e.s, e.last);
      end
   endtask

   always @(negedge clk) begin
      exp_t g;
      if (rst) begin
         a_stall = 1'b0;
      end else begin
         g = get_a();
         if (a_stall) begin
            check("stall_valid", longint'(a_valid), 1);
            chk_ray("stall_hold", g, a_snap);
         end
         if (a_valid && a_ready) begin
            if (a_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ray_a: got x=%0d y=%0d want none", a_x, a_y);
            end else begin
               chk_ray("ray_a", g, a_q.pop_front());
            end
         end
         a_stall = a_valid && !a_ready;
         a_snap  = g;
      end
   end

   always @(negedge clk) begin
      exp_t g;
      logic [31:0] dx;
      logic [31:0] dy;
      if (!rst && b_valid) begin
         g = get_b();
         if (b_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ray_b: got x=%0d s=%0d want none", b_x, b_s);
         end else begin
            chk_ray("ray_b", g, b_q.pop_front());
         end
         dx = g.d[0] - (32'hFFFF0000 + 32'(g.x) * 32'h8000);
         dy = g.d[1] - 32'h00010000;
         check("jit_x_range", longint'($signed(dx) >= -16384 && $signed(dx) <= 16384), 1);
         check("jit_y_range", longint'($signed(dy) >= -16384 && $signed(dy) <= 16384), 1);
      end
   end

   initial begin
      int k = 0;
      a_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) begin
            a_ready = pat[k];
            k = (k + 1) % 4;
         end else begin
            a_ready = 1'b1;
            k = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input int w, h);
      a_w = 11'(w);
      a_h = 11'(h);
      a_start = 1'b1;
      step();
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input int c0, input int exp_cyc);
      int cyc = c0;
      while (!a_done && cyc < 300) begin
         step();
         cyc++;
      end
      check("done_seen", longint'(a_done), 1);
      if (exp_cyc >= 0) check("done_cyc", cyc, exp_cyc);
      check("busy_fall", longint'(a_busy), 0);
      step();
      check("done_pulse", longint'(a_done), 0);
      check("drained_a", a_q.size(), 0);
   endtask

   task automatic set_cam1();
      p00[0] = 32'hFFFF0000; p00[1] = 32'h00010000; p00[2] = 32'hFFFF0000;
      du[0] = 32'h00008000; du[1] = 32'h0; du[2] = 32'h0;
      dv[0] = 32'h0; dv[1] = 32'hFFFF8000; dv[2] = 32'h0;
      for (int i = 0; i < 3; i++) cc[i] = 32'h0;
   endtask

   task automatic push_s1();
      a_q.push_back(mk(32'hFFFF0000, 32'h00010000, 32'hFFFF0000, 0, 0, 0, 0, 0, 0, 1'b0));
      a_q.push_back(mk(32'hFFFF8000, 32'h00010000, 32'hFFFF0000, 0, 0, 0, 1, 0, 0, 1'b0));
      a_q.push_back(mk(32'hFFFF0000, 32'h00008000, 32'hFFFF0000, 0, 0, 0, 0, 1, 0, 1'b0));
      a_q.push_back(mk(32'hFFFF8000, 32'h00008000, 32'hFFFF0000, 0, 0, 0, 1, 1, 0, 1'b1));
   endtask

   task automatic scen1(input bit timed);
      set_cam1();
      push_s1();
      start_a(2, 2);
      if (timed) begin
         check("busy_run", longint'(a_busy), 1);
         for (int k = 1; k <= 4; k++) begin
            step();
            check("first_valid", longint'(a_valid), longint'(k == 4));
         end
         wait_done_a(4, 8);
      end else begin
         wait_done_a(0, -1);
      end
   endtask

   task automatic run_b();
      logic [15:0] l;
      logic [15:0] l1;
      logic [31:0] sx;
      logic [31:0] sy;
      int cyc;
      l = 16'h1234;
      for (int x = 0; x < 3; x++) begin
         for (int s = 0; s < 4; s++) begin
            l1 = lstep(l);
            sx = (32'(x) << 16) + 32'(l) - 32'h8000;
            sy = 32'(l1) - 32'h8000;
            l = lstep(l1);
            b_q.push_back(mk(32'hFFFF0000 + mq(sx, 32'h00008000),
                             32'h00010000 + mq(sy, 32'hFFFF8000),
                             32'hFFFF0000, 0, 0, 0, x, 0, s,
                             1'((x == 2) && (s == 3))));
         end
      end
      b_w = 11'd3;
      b_h = 11'd1;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      cyc = 0;
      while (!b_done && cyc < 300) begin
         step();
         cyc++;
      end
      check("b_done_cyc", cyc, 16);
      step();
      check("drained_b", b_q.size(), 0);
   endtask

   initial begin
      int nv;
      rst = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      a_w = '0; a_h = '0; b_w = '0; b_h = '0;
      seed = 16'h0;
      set_cam1();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", longint'(a_valid), 0);
      check("rst_busy", longint'(a_busy), 0);
      check("rst_done", longint'(a_done), 0);
      check("rst_last", longint'(a_last), 0);
      check("rst_dir", longint'(a_dir[0]), 0);
      check("rst_b_valid", longint'(b_valid), 0);
      rst = 1'b0;
      step();

      scen1(1'b1);

      tog_en = 1'b1;
      scen1(1'b0);
      tog_en = 1'b0;
      step();

      set_cam1();
      push_s1();
      start_a(2, 2);
      repeat (5) step();
      check("pre_rst_valid", longint'(a_valid), 1);
      check("pre_rst_x", longint'(a_x), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", longint'(a_valid), 0);
      check("mid_rst_busy", longint'(a_busy), 0);
      check("mid_rst_done", longint'(a_done), 0);
      check("mid_rst_dirx", longint'(a_dir[0]), 0);
      check("mid_rst_diry", longint'(a_dir[1]), 0);
      check("mid_rst_x", longint'(a_x), 0);
      a_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      scen1(1'b1);

      start_a(0, 5);
      check("zero_done", longint'(a_done), 1);
      check("zero_busy", longint'(a_busy), 0);
      step();
      check("zero_done_pulse", longint'(a_done), 0);
      nv = 0;
      for (int k = 0; k < 10; k++) begin
         if (a_valid) nv++;
         step();
      end
      check("zero_rays", nv, 0);

      p00[0] = 32'h00010000; p00[1] = 32'h00020000; p00[2] = 32'h00030000;
      for (int i = 0; i < 3; i++) begin
         du[i] = 32'h0;
         dv[i] = 32'h0;
      end
      cc[0] = 32'h00008000; cc[1] = 32'hFFFF0000; cc[2] = 32'h00030000;
      a_q.push_back(mk(32'h00008000, 32'h00030000, 32'h0,
                       32'h00008000, 32'hFFFF0000, 32'h00030000, 0, 0, 0, 1'b1));
      start_a(1, 1);
      wait_done_a(0, 5);

      for (int i = 0; i < 3; i++) begin
         p00[i] = 32'h0;
         du[i] = 32'h0;
         dv[i] = 32'h0;
         cc[i] = 32'h0;
      end
      du[0] = 32'h7FFF0000;
      a_q.push_back(mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
      a_q.push_back(mk(32'h7FFF0000, 0, 0, 0, 0, 0, 1, 0, 0, 1'b0));
      a_q.push_back(mk(32'hFFFE0000, 0, 0, 0, 0, 0, 2, 0, 0, 1'b1));
      start_a(3, 1);
      repeat (2) step();
      a_w = 11'd5;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      wait_done_a(3, 7);

      set_cam1();
      seed = 16'h1234;
      run_b();
      run_b();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rt_rgu_scan.md
# rt_rgu_scan

Pipelined, frame-scanning ray generation unit. It latches a camera description on `start` and walks every pixel of an `img_w` x `img_h` image, with `SPP` samples per pixel and optional LFSR sub-pixel jitter. Each sample yields one primary ray in signed fixed point, handed over on a valid/ready stream. It sits between the frame controller and the intersection pipeline, and replaces the combinational per-pixel ray generator.

## Interface
Parameters:
- `IW`, 16: integer bits of signed fixed-point words; word length `WL = IW+QW`.
- `QW`, 16: fraction bits.
- `XW`, 11: width of x counter and `img_w`.
- `YW`, 11: width of y counter and `img_h`.
- `SPP_LOG2`, 0: log2 of samples per pixel (`SPP = 2**SPP_LOG2`).
- `JITTER`, 0: 1 = add LFSR sub-pixel offsets; 0 = no offset.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `img_w` in XW, `img_h` in YW: image size; latched on accepted start.
- `pixel_00_loc[3]`, `pixel_delta_u[3]`, `pixel_delta_v[3]`, `camera_center[3]` in WL each: camera vectors; latched on accepted start.
- `seed` in 16: LFSR seed; latched on accepted start. Value 0 is replaced by 16'hACE1.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse at frame end.
- `ray_valid` out 1, `ray_ready` in 1: output handshake.
- `ray_origin[3]`, `ray_direction[3]` out WL each: ray vectors.
- `ray_x` out XW, `ray_y` out YW, `ray_sample` out max(1,SPP_LOG2): tag of the ray.
- `ray_last` out 1: high on the final ray of the frame.

## Operation
- States:
  - IDLE -> RUN on `start`, if `img_w != 0` and `img_h != 0`.
  - IDLE -> DONE on `start` when either dimension is 0; no rays are emitted.
  - RUN -> DRAIN after the last sample is issued into the pipe.
  - DRAIN -> DONE when the `ray_last` handshake completes.
  - DONE -> IDLE unconditionally. `done` = 1 only in the DONE state.
- `start` in any state other than IDLE is ignored. Latched inputs are not re-read mid-frame.
- Issue order: sample is the innermost loop, then x, then y. Counters reset to 0 on start. Sample wraps to 0 and increments x; x wraps at `img_w-1` and increments y.
- Sample coordinate:
  - `sx = (x<<QW) + ox`, `sy = (y<<QW) + oy`.
  - With JITTER=0: `ox = oy = 0`.
  - With JITTER=1: `ox = {lfsr[QW-1:0]} - (1<<(QW-1))` and `oy` uses the next LFSR state, so offsets lie in [-0.5, 0.5).
  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It steps twice per issued sample. When QW > 16, the offset is zero-extended at the LSB end.
- Direction: `pixel_00_loc + sx*delta_u + sy*delta_v - camera_center`, computed per component.
  - Each product is full precision, arithmetic-shifted right by QW (floor), then truncated to WL bits.
  - All adds and subtracts wrap modulo 2^WL; there is no saturation.
- `ray_origin` = latched `camera_center`.

## Timing
- Pipeline has 3 register stages: coordinate/offset, multiply, sum/subtract. A sample issued in cycle t is presented on the output at t+3 when there is no stall.
- Global stall: when `ray_valid && !ray_ready`, all stages, counters and the LFSR hold.
  - Outputs hold stable while stalled.
  - `ray_valid` never drops without a handshake.
- Throughput is 1 ray/cycle with `ray_ready` = 1. The first ray appears 4 cycles after the accepted `start` edge.
- `done` pulses the cycle after the `ray_last` handshake; `busy` falls in the same cycle.
- Reset values:
  - state IDLE; `busy`, `done`, `ray_valid`, `ray_last` = 0.
  - All data/tag outputs = 0; counters = 0; LFSR = 16'hACE1; pipeline valid bits cleared.
- Reset mid-frame aborts immediately: no `done`, no further rays. The next `start` begins a fresh frame.

## Test plan
- IW=QW=16, SPP_LOG2=0, JITTER=0; img 2x2; p00=(-1.0, 1.0, -1.0), du=(0.5, 0, 0), dv=(0, -0.5, 0), center=0; `ray_ready` tied 1.
  - Required directions in order: (-1, 1, -1), (-0.5, 1, -1), (-1, 0.5, -1), (-0.5, 0.5, -1).
  - `ray_last` on the 4th ray only; tags (0,0), (1,0), (0,1), (1,1); `done` 1 cycle after; first valid at cycle start+4.
- Same setup, `ray_ready` toggling 1,0,0,1 repeating: identical ray sequence, outputs stable during stalls, no loss and no duplication.
- SPP_LOG2=2, JITTER=1, seed=16'h1234, img 3x1: 12 rays with sample tags 0..3 per pixel; all offsets within ±0.5·du of the JITTER=0 directions. A repeated frame with the same seed is bit-identical.
- img_w=0, img_h=5 -> `done` pulse 1 cycle after start, zero `ray_valid`.
- `rst` asserted while the 2nd ray is valid -> all outputs 0 the same cycle. A subsequent start reproduces the scenario 1 sequence.
- du=(0x7FFF_0000, 0, 0), p00=0, center=0, x=1 wraps correctly. x=2 -> dir.x = 0xFFFE_0000 (wrapped). A `start` pulse while busy is ignored.
